// File: rtl/unigate_pkg.sv
// Shared definitions for the unigate block family:
// gate-size select codes, sweep states and sweep geometry.
package unigate_pkg;

   localparam logic [1:0] SEL_U21 = 2'b00;
   localparam logic [1:0] SEL_U31 = 2'b01;
   localparam logic [1:0] SEL_U41 = 2'b10;
   localparam logic [1:0] SEL_U22 = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   typedef struct packed {
      logic [4:0]  count;
      logic [15:0] mask;
   } sweep_cfg_t;

   // Number of input combinations and valid-bit mask for a gate size.
   function automatic sweep_cfg_t sweep_cfg(input logic [1:0] sel);
      sweep_cfg_t cfg;
      unique case (sel)
         SEL_U31: cfg = '{count: 5'd8, mask: 16'h00FF};
         SEL_U41: cfg = '{count: 5'd16, mask: 16'hFFFF};
         default: cfg = '{count: 5'd4, mask: 16'h000F};
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/unigate_truth_sampler.sv
// Sweeps every input vector into one gate, waits a settle window per vector
// and reconstructs the gate's truth table as a unigate function code.
module unigate_truth_sampler
   import unigate_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start_i,
   input  logic [1:0]  sel_i,
   input  logic [15:0] expect_i,
   output logic [3:0]  probe_o,
   input  logic        gate_i,
   output logic        busy_o,
   output logic        tt_valid_o,
   input  logic        tt_ready_i,
   output logic [15:0] tt_o,
   output logic        match_o
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t            state;
   state_t            state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        probe;
   logic [15:0]       tt;
   logic [15:0]       exp_q;
   logic [1:0]        sel_q;
   sweep_cfg_t        cfg;
   logic              last;

   assign cfg  = sweep_cfg(sel_q);
   assign last = ({1'b0, probe} == (cfg.count - 5'd1));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (start_i)      state_nx = SETTLE;
         SETTLE: if (cnt == '0)    state_nx = SAMPLE;
         SAMPLE: state_nx = last ? DONE : SETTLE;
         DONE:   if (tt_ready_i)   state_nx = IDLE;
      endcase
   end

   // Probe only moves on the SAMPLE exit edge, so it is stable
   // for the whole settle window preceding every sample.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cnt   <= '0;
         probe <= '0;
         tt    <= '0;
         exp_q <= '0;
         sel_q <= SEL_U21;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  sel_q <= sel_i;
                  exp_q <= expect_i;
                  tt    <= '0;
                  probe <= '0;
                  cnt   <= CNT_LOAD;
               end
            end
            SETTLE: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            SAMPLE: begin
               tt[probe] <= gate_i;
               if (last) begin
                  probe <= '0;
               end else begin
                  probe <= probe + 4'd1;
                  cnt   <= CNT_LOAD;
               end
            end
            DONE: begin
            end
         endcase
      end
   end

   always_comb begin
      probe_o    = probe;
      tt_o       = tt;
      busy_o     = (state == SETTLE) || (state == SAMPLE);
      tt_valid_o = (state == DONE);
      match_o    = (state == DONE) && (tt == (exp_q & cfg.mask));
   end

endmodule

// File: doc/unigate_truth_sampler.md
Name: unigate_truth_sampler

Overview:
- Stimulus-side counterpart to the unigate configurable-gate array: sweeps every input combination into one gate output and reconstructs its truth table.
- For each combination it drives probe_o, waits a settle window, then samples gate_i. It assembles a 16-bit function code in the same format the unigate reference mode loads: bit k = gate output for input vector k.
- Sits next to unigate for self-test and characterisation.
- Results leave on a valid/ready port, with a compare-against-expected flag.

Parameters:
- SETTLE_CYCLES, 4, cycles probe_o is held before sampling; legal range 1..255.
- CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  start request; honoured only in IDLE.
- sel_i  in  2  gate-size select, latched at start: 00→2 inputs, 01→3, 10→4, 11→2.
- expect_i  in  16  expected function code, latched at start.
- probe_o  out  4  input vector driven to the gate; bit0 = a (LSB), bit3 = d.
- gate_i  in  1  gate output under test.
- busy_o  out  1  high in SETTLE or SAMPLE.
- tt_valid_o  out  1  truth table available.
- tt_ready_i  in  1  consumer accepts the table.
- tt_o  out  16  captured truth table; bits ≥ C are 0.
- match_o  out  1  tt_o == (expect_latched & mask); valid only while tt_valid_o is high.

Behaviour:
- Combination count C and mask by latched sel:
  - 00 or 11: C = 4, mask 0x000F.
  - 01: C = 8, mask 0x00FF.
  - 10: C = 16, mask 0xFFFF.
- Reset values, applied at the reset edge, taking priority over everything:
  - outputs: probe_o = 0, tt_o = 0, tt_valid_o = 0, match_o = 0, busy_o = 0.
  - internal: state = IDLE, cnt = 0.
- State IDLE:
  - probe_o = 0.
  - On start_i = 1: latch sel_i and expect_i, clear the tt shift/accumulator, probe = 0, cnt = SETTLE_CYCLES-1, go to SETTLE.
- State SETTLE:
  - probe_o held.
  - cnt decrements each cycle.
  - When cnt == 0, go to SAMPLE.
- State SAMPLE, one cycle:
  - At the exiting edge, tt[probe] <= gate_i.
  - If probe == C-1, go to DONE.
  - Otherwise probe <= probe+1, cnt <= SETTLE_CYCLES-1, go to SETTLE.
- State DONE:
  - tt_valid_o = 1, probe_o = 0.
  - tt_o and match_o are stable and must not change while valid && !ready.
  - On tt_ready_i = 1, go to IDLE and drop valid next cycle. tt_o keeps its value until the next start.
- Latency:
  - Each combination takes SETTLE_CYCLES+1 cycles.
  - tt_valid_o rises C*(SETTLE_CYCLES+1) cycles after the start-accept edge; with defaults and sel = 10 that is 80 cycles.
- Boundary rules:
  - start_i while busy or in DONE is ignored; no queuing.
  - start_i in the same cycle as the DONE handshake is ignored; the next start is honoured one cycle later in IDLE.
  - sel_i / expect_i changes after start have no effect.
  - probe_o changes only at the SAMPLE→SETTLE edge, so it is glitch-free with respect to the sample point.
  - Reset mid-sweep aborts immediately. Partial table is discarded (tt_o = 0); no valid is emitted.
  - tt_ready_i outside DONE is ignored.
  - SETTLE_CYCLES = 1 gives 2 cycles per combination.

Decomposition:
- Shared package unigate_pkg:
  - sel encodings SEL_U21 = 2'b00, SEL_U31 = 2'b01, SEL_U41 = 2'b10, SEL_U22 = 2'b11.
  - state enum IDLE/SETTLE/SAMPLE/DONE.
  - function returning C and mask from sel.
- No sub-module needed. The sweep FSM, settle counter and tt accumulator are one block. The settle counter could be split out as unigate_settle_timer if reused elsewhere; that is not required.

Test Plan:
- sel = 00, model gate = probe[0]^probe[1], expect 0x0006 → tt_o = 0x0006, match_o = 1, valid after 20 cycles (SETTLE = 4).
- sel = 10, gate = &probe, expect 0x8000 → tt_o = 0x8000, match_o = 1, valid exactly 80 cycles after start; probe_o steps 0..15 with each value held 5 cycles.
- sel = 10, gate = ^probe (parity), expect 0x6996 → tt_o = 0x6996, match_o = 1; same run with expect 0x6997 → match_o = 0.
- sel = 01, gate = majority(a,b,c), expect 0xFFE8 → tt_o = 0x00E8 (upper bits 0), match_o = 1 (mask applied).
- Backpressure: hold tt_ready_i = 0 for 10 cycles after valid and pulse start_i in between → tt_o/match_o stable, start ignored, valid drops the cycle after ready = 1.
- Reset pulse at cycle 30 of a sel = 10 sweep → next cycle: all outputs 0 and state IDLE; a new start then yields the correct table with no residue.
